// File: rtl/retire_mon_pkg.sv
// Shared constants for the retire performance monitor.
//   - FSM state encoding (S_IDLE/S_RUN/S_HALTED/S_ABORTED)
//   - RISC-V control-flow opcodes and a classifier helper
package retire_mon_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_HALTED  = 2'd2;
  localparam logic [1:0] S_ABORTED = 2'd3;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Index of each event counter in the counter bank.
  localparam int unsigned C_CYC  = 0;
  localparam int unsigned C_RET  = 1;
  localparam int unsigned C_LD   = 2;
  localparam int unsigned C_ST   = 3;
  localparam int unsigned C_CTL  = 4;
  localparam int unsigned C_TRP  = 5;
  localparam int unsigned NUM_CNT = 6;

  function automatic logic is_ctrl_op(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   i_clk   : clock
//   i_clear : synchronous clear to 0 (wins over i_inc)
//   i_inc   : count up by one, holding at all-ones
//   o_q     : current count
//   o_next  : value the counter would take on an increment (saturated)
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_next
);

  logic [W-1:0] r_q;

  assign o_next = (&r_q) ? r_q : r_q + W'(1);
  assign o_q    = r_q;

  always_ff @(posedge i_clk) begin
    if (i_clear)    r_q <= '0;
    else if (i_inc) r_q <= o_next;
  end

endmodule

// File: rtl/retire_perf_monitor.sv
// Retire-interface performance monitor.
// Counts RUN cycles, retires and instruction classes, tracks the longest
// retire gap, and detects halt / timeout / hang.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_enable, i_clear     : start (IDLE only), synchronous clear to IDLE
//   i_retire_*            : hart retire interface
//   o_state               : 0 IDLE, 1 RUN, 2 HALTED, 3 ABORTED
//   o_cycles .. o_traps   : saturating event counters
//   o_max_gap             : longest non-retire run seen in RUN
//   o_done/o_timeout      : HALTED / ABORTED decode
//   o_hang                : sticky, gap reached MAX_STALL
module retire_perf_monitor
  import retire_mon_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned TIMEOUT   = 40000,
  parameter int unsigned MAX_STALL = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic             i_retire_valid,
  input  logic [31:0]      i_retire_inst,
  input  logic             i_retire_trap,
  input  logic             i_retire_halt,
  input  logic             i_retire_dmem_ren,
  input  logic             i_retire_dmem_wen,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_cycles,
  output logic [CNT_W-1:0] o_retired,
  output logic [CNT_W-1:0] o_loads,
  output logic [CNT_W-1:0] o_stores,
  output logic [CNT_W-1:0] o_ctrl,
  output logic [CNT_W-1:0] o_traps,
  output logic [CNT_W-1:0] o_max_gap,
  output logic             o_done,
  output logic             o_timeout,
  output logic             o_hang
);

  logic [1:0] r_state, w_state_nxt;
  logic       w_clr, w_run, w_rv, w_idle_cyc;
  logic [NUM_CNT-1:0]            w_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] w_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] w_gap, w_gap_nxt;
  logic [CNT_W-1:0] r_max_gap;
  logic             r_hang;
  logic             w_unused_inst;

  assign w_unused_inst = ^{i_retire_inst[31:7], w_gap};

  assign w_clr      = i_rst | i_clear;
  assign w_run      = (r_state == S_RUN);
  assign w_rv       = w_run & i_retire_valid;
  assign w_idle_cyc = w_run & ~i_retire_valid;

  assign w_inc[C_CYC] = w_run;
  assign w_inc[C_RET] = w_rv;
  assign w_inc[C_LD]  = w_rv & i_retire_dmem_ren;
  assign w_inc[C_ST]  = w_rv & i_retire_dmem_wen;
  assign w_inc[C_CTL] = w_rv & is_ctrl_op(i_retire_inst[6:0]);
  assign w_inc[C_TRP] = w_rv & i_retire_trap;

  // Event counter bank; nothing increments outside RUN, so they freeze
  // in the terminal states.
  genvar g;
  generate
    for (g = 0; g < NUM_CNT; g++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
        .i_clk  (i_clk),
        .i_clear(w_clr),
        .i_inc  (w_inc[g]),
        .o_q    (w_cnt[g]),
        .o_next (w_cnt_nxt[g])
      );
    end
  endgenerate

  // Gap counter restarts on every retire observed in RUN.
  sat_counter #(.W(CNT_W)) u_gap (
    .i_clk  (i_clk),
    .i_clear(w_clr | w_rv),
    .i_inc  (w_idle_cyc),
    .o_q    (w_gap),
    .o_next (w_gap_nxt)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_state <= S_IDLE;
    else if (i_clear) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next-state: a halting retire beats a timeout landing on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_enable) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_rv && i_retire_halt)
          w_state_nxt = S_HALTED;
        else if (TIMEOUT != 0 && 64'(w_cnt_nxt[C_CYC]) == 64'(TIMEOUT))
          w_state_nxt = S_ABORTED;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    o_state   = r_state;
    o_done    = (r_state == S_HALTED);
    o_timeout = (r_state == S_ABORTED);
  end

  // Max gap compares against the post-increment gap so it updates on the
  // same edge as the gap counter.
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_max_gap <= '0;
      r_hang    <= 1'b0;
    end else if (w_idle_cyc) begin
      if (w_gap_nxt > r_max_gap) r_max_gap <= w_gap_nxt;
      if (MAX_STALL != 0 && 64'(w_gap_nxt) >= 64'(MAX_STALL)) r_hang <= 1'b1;
    end
  end

  assign o_cycles  = w_cnt[C_CYC];
  assign o_retired = w_cnt[C_RET];
  assign o_loads   = w_cnt[C_LD];
  assign o_stores  = w_cnt[C_ST];
  assign o_ctrl    = w_cnt[C_CTL];
  assign o_traps   = w_cnt[C_TRP];
  assign o_max_gap = r_max_gap;
  assign o_hang    = r_hang;

endmodule
